// File: rtl/ntt_pkg.sv
// ntt_pkg: shared constants, FSM state encoding and the coefficient-to-bank
// mapping for the NTT bank loader.
//   N      : transform length (512)
//   NBANK  : number of coefficient banks (4)
//   AW     : bank address width (N/4 words per bank)
//   DATA_W : coefficient width
//   IDX_W  : index counter width; one bit wider than log2(N) so the terminal
//            count N itself can be represented and detected.
package ntt_pkg;

  localparam int N      = 512;
  localparam int NBANK  = 4;
  localparam int AW     = 7;
  localparam int DATA_W = 14;
  localparam int IDX_W  = 10;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    UNLOAD,
    FLUSH
  } state_t;

  // Conflict-free bank rotation: sum of the 2-bit digits of the index (plus
  // the top bit) modulo 4. The 2-bit return width performs the modulo.
  function automatic logic [1:0] bank_of(input logic [8:0] i);
    return i[1:0] + i[3:2] + i[5:4] + i[7:6] + {1'b0, i[8]};
  endfunction

  // Word address inside the selected bank.
  function automatic logic [AW-1:0] addr_of(input logic [8:0] i);
    return i[8:2];
  endfunction

endpackage

// File: rtl/ntt_bank_loader_if.sv
// ntt_bank_loader_if: input stream, output stream and the four-bank
// coefficient memory port of the loader.
//   in_data/in_valid/in_ready    : coefficient input stream (LOAD)
//   out_data/out_valid/out_ready : coefficient output stream (UNLOAD)
//   bank_we/addr/wdata/rdata     : per-bank memory port; bank b uses slice
//                                  [b*AW +: AW] / [b*DATA_W +: DATA_W];
//                                  bank_rdata is valid one cycle after addr.
// master = the loader, slave = the surrounding system (streams + banks).
interface ntt_bank_loader_if;
  import ntt_pkg::*;

  logic [DATA_W-1:0]       in_data;
  logic                    in_valid;
  logic                    in_ready;
  logic [DATA_W-1:0]       out_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [NBANK-1:0]        bank_we;
  logic [NBANK*AW-1:0]     bank_addr;
  logic [NBANK*DATA_W-1:0] bank_wdata;
  logic [NBANK*DATA_W-1:0] bank_rdata;

  modport master (
    input  in_data, in_valid, out_ready, bank_rdata,
    output in_ready, out_data, out_valid, bank_we, bank_addr, bank_wdata
  );

  modport slave (
    output in_data, in_valid, out_ready, bank_rdata,
    input  in_ready, out_data, out_valid, bank_we, bank_addr, bank_wdata
  );

endinterface

// File: rtl/skid_fifo2.sv
// skid_fifo2: 2-entry FIFO absorbing the one-cycle bank read latency so the
// output stream can stall without losing returning read data.
//   clk, rst : clock, synchronous active-high reset
//   push/din : write din at the tail (caller never pushes when full unless
//              popping in the same cycle)
//   pop      : drop the head (caller only pops when count != 0)
//   count    : number of stored words (0..2)
//   head     : oldest stored word
module skid_fifo2 #(
  parameter int W = 14
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [1:0]   count,
  output logic [W-1:0] head
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;

  // NOTE: sequential state uses non-blocking (<=) assignments so every
  // register samples the pre-edge value of its inputs, independent of
  // statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the two storage words are reset as well, because head drives
      // out_data directly and must read 0 after reset; a deep RAM would not
      // be reset this way.
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      // Simultaneous push and pop leave the count unchanged.
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/ntt_bank_loader.sv
// ntt_bank_loader: streams 512 natural-order coefficients into the four NTT
// coefficient banks (LOAD) and streams them back out in natural order with
// backpressure (UNLOAD).
//   clk, rst : clock, synchronous active-high reset
//   start    : one-cycle request, sampled only in IDLE
//   mode     : sampled with start; 0 = LOAD, 1 = UNLOAD
//   busy     : high in every state except IDLE
//   done     : one-cycle pulse after a load or unload completes
//   bus      : streams and bank port (see ntt_bank_loader_if)
module ntt_bank_loader
  import ntt_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  output logic              busy,
  output logic              done,
  ntt_bank_loader_if.master bus
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
  localparam logic [IDX_W-1:0] END_IDX  = IDX_W'(N);

  state_t                  state;
  state_t                  state_nxt;
  logic                    done_nxt;
  logic [IDX_W-1:0]        idx;
  logic [1:0]              cur_bank;
  logic [AW-1:0]           cur_addr;
  logic                    in_hs;
  logic                    pop;
  logic                    rd_issue;
  logic [2:0]              occupancy;
  logic                    in_flight;
  logic [1:0]              rd_bank_q;
  logic [1:0]              fifo_count;
  logic [DATA_W-1:0]       fifo_head;
  logic [DATA_W-1:0]       rd_word;
  logic [NBANK-1:0]        we_q;
  logic [NBANK*AW-1:0]     waddr_q;
  logic [NBANK*AW-1:0]     raddr;
  logic [NBANK*DATA_W-1:0] wdata_q;

  assign cur_bank = bank_of(idx[IDX_W-2:0]);
  assign cur_addr = addr_of(idx[IDX_W-2:0]);

  // Input is accepted only while LOAD still has indices left; once idx hits
  // N the final write is draining and in_ready must already be low.
  assign bus.in_ready = (state == LOAD) && !idx[IDX_W-1];
  assign in_hs        = bus.in_ready && bus.in_valid;

  assign bus.out_valid = (fifo_count != 2'd0);
  assign bus.out_data  = fifo_head;
  assign pop           = bus.out_valid && bus.out_ready;

  // A read may issue when the words already owed to the FIFO (queued plus
  // in flight), net of this cycle's pop, leave room for one more. Counting
  // the pop keeps throughput at one word per cycle with out_ready high; the
  // price is a combinational path from out_ready to bank_addr.
  assign occupancy = {1'b0, fifo_count} + {2'b00, in_flight} - {2'b00, pop};
  assign rd_issue  = (state == UNLOAD) && (occupancy < 3'd2);

  // FSM next state.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // through the case can leave it unassigned and infer a latch.
    state_nxt = state;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = mode ? UNLOAD : LOAD;
        end
      end
      LOAD: begin
        // idx reaches N in the cycle the write of index N-1 is on the banks.
        if (idx == END_IDX) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      UNLOAD: begin
        if (rd_issue && (idx == LAST_IDX)) begin
          state_nxt = FLUSH;
        end
      end
      FLUSH: begin
        // Last word: nothing in flight, one word left, and it leaves now.
        if (!in_flight && (fifo_count == 2'd1) && pop) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM state, index counter and read-tracking registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      done      <= 1'b0;
      idx       <= '0;
      in_flight <= 1'b0;
      rd_bank_q <= 2'd0;
    end else begin
      state     <= state_nxt;
      done      <= done_nxt;
      in_flight <= rd_issue;
      rd_bank_q <= cur_bank;
      if (state == IDLE) begin
        idx <= '0;
      end else if (in_hs || rd_issue) begin
        idx <= idx + IDX_W'(1);
      end
    end
  end

  // Write port: registered one cycle after the input handshake, and
  // all-zero in every other cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q    <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      we_q    <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      if (in_hs) begin
        we_q[cur_bank]                     <= 1'b1;
        waddr_q[cur_bank*AW +: AW]         <= cur_addr;
        wdata_q[cur_bank*DATA_W +: DATA_W] <= bus.in_data;
      end
    end
  end

  // Read address is presented combinationally on the selected bank only.
  always_comb begin
    raddr = '0;
    if (rd_issue) begin
      raddr[cur_bank*AW +: AW] = cur_addr;
    end
  end

  // Reads and writes never overlap (UNLOAD vs LOAD), so OR-ing is a mux.
  assign bus.bank_we    = we_q;
  assign bus.bank_addr  = waddr_q | raddr;
  assign bus.bank_wdata = wdata_q;

  assign rd_word = bus.bank_rdata[rd_bank_q*DATA_W +: DATA_W];

  skid_fifo2 #(
    .W (DATA_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_flight),
    .pop   (pop),
    .din   (rd_word),
    .count (fifo_count),
    .head  (fifo_head)
  );

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_ntt_bank_loader.sv
// tb_ntt_bank_loader: directed bench for ntt_bank_loader. Models the four
// coefficient banks as synchronous RAMs with one-cycle read latency. Inputs
// change 1 time unit after the rising edge; outputs are sampled on the
// falling edge. Cycle 0 is the cycle in which start is high.
module tb_ntt_bank_loader;
  import ntt_pkg::*;

  localparam int WV = 4 + 4 * AW + 4 * DATA_W;
  typedef logic [WV-1:0] wv_t;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic mode;
  logic busy;
  logic done;
  logic preload_req = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  ntt_bank_loader_if bus ();

  ntt_bank_loader dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .mode  (mode),
    .busy  (busy),
    .done  (done),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference bank mapping, written independently from the RTL helper.
  function automatic int tbank(int i);
    return ((i & 3) + ((i >> 2) & 3) + ((i >> 4) & 3) + ((i >> 6) & 3) + ((i >> 8) & 1)) % 4;
  endfunction

  function automatic wv_t exp_wr(int i, int d);
    logic [3:0]          we = '0;
    logic [4*AW-1:0]     a  = '0;
    logic [4*DATA_W-1:0] w  = '0;
    int b = tbank(i);
    we[b]                = 1'b1;
    a[b*AW +: AW]        = AW'(i >> 2);
    w[b*DATA_W +: DATA_W] = DATA_W'(d);
    return {we, a, w};
  endfunction

  function automatic logic [4*AW-1:0] exp_raddr(int i);
    logic [4*AW-1:0] a = '0;
    a[tbank(i)*AW +: AW] = AW'(i >> 2);
    return a;
  endfunction

  // Bank model: four synchronous RAMs; preload_req fills word i with value i.
  logic [DATA_W-1:0] mem [4][128];
  always @(posedge clk) begin
    if (preload_req) begin
      for (int i = 0; i < 512; i++) mem[tbank(i)][i >> 2] <= DATA_W'(i);
    end
    for (int b = 0; b < 4; b++) begin
      if (bus.bank_we[b]) mem[b][bus.bank_addr[b*AW +: AW]] <= bus.bank_wdata[b*DATA_W +: DATA_W];
      bus.bank_rdata[b*DATA_W +: DATA_W] <= mem[b][bus.bank_addr[b*AW +: AW]];
    end
  end

  wire wv_t wr_bus = {bus.bank_we, bus.bank_addr, bus.bank_wdata};

  task automatic do_preload();
    @(posedge clk); #1 preload_req = 1'b1;
    @(posedge clk); #1 preload_req = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; mode = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if ({busy, done, bus.in_ready, bus.out_valid} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_ctrl got %b exp 0000", {busy, done, bus.in_ready, bus.out_valid});
    end
    n_tests++;
    if (bus.out_data !== '0) begin
      n_fail++; $display("FAIL reset_out_data got %h exp 0", bus.out_data);
    end
    n_tests++;
    if (wr_bus !== '0) begin
      n_fail++; $display("FAIL reset_bank_port got %h exp 0", wr_bus);
    end
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_load_stream();
    wv_t exp;
    @(posedge clk); #1 start = 1'b1; mode = 1'b0; bus.in_valid = 1'b1; bus.in_data = '0;
    for (int c = 1; c <= 516; c++) begin
      @(posedge clk); #1 start = 1'b0; bus.in_data = DATA_W'(c - 1);
      @(negedge clk);
      n_tests++;
      if (bus.in_ready !== (c <= 512)) begin
        n_fail++; $display("FAIL load_in_ready c=%0d got %b exp %b", c, bus.in_ready, (c <= 512));
      end
      exp = (c >= 2 && c <= 513) ? exp_wr(c - 2, c - 2) : '0;
      n_tests++;
      if (wr_bus !== exp) begin
        n_fail++; $display("FAIL load_write c=%0d got %h exp %h", c, wr_bus, exp);
      end
      n_tests++;
      if (done !== (c == 514) || busy !== (c <= 513)) begin
        n_fail++; $display("FAIL load_done_busy c=%0d got %b%b exp %b%b", c, done, busy, (c == 514), (c <= 513));
      end
      // i=5: digits 1+1 -> bank 2, addr 1.
      if (c == 7) begin
        n_tests++;
        if (bus.bank_we !== 4'b0100 || bus.bank_addr[2*AW +: AW] !== 7'd1) begin
          n_fail++; $display("FAIL load_i5 got we=%b addr=%0d exp we=0100 addr=1", bus.bank_we, bus.bank_addr[2*AW +: AW]);
        end
      end
      // i=300 = 1_00_10_11_00b: (0+3+2+0+1) mod 4 = 2, addr 75.
      if (c == 302) begin
        n_tests++;
        if (bus.bank_we !== 4'b0100 || bus.bank_addr[2*AW +: AW] !== 7'd75
            || bus.bank_wdata[2*DATA_W +: DATA_W] !== 14'd300) begin
          n_fail++; $display("FAIL load_i300 got we=%b addr=%0d data=%0d exp we=0100 addr=75 data=300",
                             bus.bank_we, bus.bank_addr[2*AW +: AW], bus.bank_wdata[2*DATA_W +: DATA_W]);
        end
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_load_toggle();
    wv_t exp;
    logic pending = 1'b0;
    logic exp_ready;
    int p_idx = 0, p_data = 0, nhs = 0, nwr = 0, last_wr = -10;
    @(posedge clk); #1 start = 1'b1; mode = 1'b0; bus.in_valid = 1'b0;
    for (int c = 1; c <= 1028; c++) begin
      @(posedge clk); #1 start = 1'b0; bus.in_valid = c[0]; bus.in_data = DATA_W'(c * 37 + 5);
      @(negedge clk);
      exp = pending ? exp_wr(p_idx, p_data) : '0;
      n_tests++;
      if (wr_bus !== exp) begin
        n_fail++; $display("FAIL toggle_write c=%0d got %h exp %h", c, wr_bus, exp);
      end
      if (pending) begin nwr++; last_wr = c; end
      n_tests++;
      if (done !== (nwr == 512 && c == last_wr + 1)) begin
        n_fail++; $display("FAIL toggle_done c=%0d got %b exp %b", c, done, (nwr == 512 && c == last_wr + 1));
      end
      exp_ready = (nhs < 512);
      n_tests++;
      if (bus.in_ready !== exp_ready) begin
        n_fail++; $display("FAIL toggle_in_ready c=%0d got %b exp %b", c, bus.in_ready, exp_ready);
      end
      pending = bus.in_valid && exp_ready;
      if (pending) begin p_idx = nhs; p_data = int'(bus.in_data); nhs++; end
    end
    n_tests++;
    if (nwr != 512) begin
      n_fail++; $display("FAIL toggle_write_count got %0d exp 512", nwr);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_unload_stream();
    logic [4*AW-1:0] exp_a;
    do_preload();
    @(posedge clk); #1 start = 1'b1; mode = 1'b1; bus.out_ready = 1'b1;
    for (int c = 1; c <= 517; c++) begin
      @(posedge clk); #1 start = 1'b0;
      @(negedge clk);
      n_tests++;
      if (bus.out_valid !== (c >= 3 && c <= 514)) begin
        n_fail++; $display("FAIL unload_valid c=%0d got %b exp %b", c, bus.out_valid, (c >= 3 && c <= 514));
      end
      if (c >= 3 && c <= 514) begin
        n_tests++;
        if (bus.out_data !== DATA_W'(c - 3)) begin
          n_fail++; $display("FAIL unload_data c=%0d got %0d exp %0d", c, bus.out_data, c - 3);
        end
      end
      n_tests++;
      if (done !== (c == 515) || busy !== (c <= 514)) begin
        n_fail++; $display("FAIL unload_done_busy c=%0d got %b%b exp %b%b", c, done, busy, (c == 515), (c <= 514));
      end
      exp_a = (c <= 512) ? exp_raddr(c - 1) : '0;
      n_tests++;
      if (bus.bank_addr !== exp_a || bus.bank_we !== 4'b0000) begin
        n_fail++; $display("FAIL unload_addr c=%0d got %h/%b exp %h/0000", c, bus.bank_addr, bus.bank_we, exp_a);
      end
    end
  endtask

  task automatic test_unload_random();
    int nxt = 0, last_pop = -10;
    logic stalled = 1'b0, seen_done = 1'b0;
    logic [DATA_W-1:0] held = '0;
    do_preload();
    @(posedge clk); #1 start = 1'b1; mode = 1'b1; bus.out_ready = 1'b0;
    for (int c = 1; c <= 3000 && !seen_done; c++) begin
      @(posedge clk); #1 start = 1'b0; bus.out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (stalled) begin
        n_tests++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== held) begin
          n_fail++; $display("FAIL rand_stall c=%0d got %b/%0d exp 1/%0d", c, bus.out_valid, bus.out_data, held);
        end
      end
      if (bus.out_valid === 1'b1 && bus.out_ready) begin
        n_tests++;
        if (bus.out_data !== DATA_W'(nxt)) begin
          n_fail++; $display("FAIL rand_data c=%0d got %0d exp %0d", c, bus.out_data, nxt);
        end
        nxt++;
        last_pop = c;
      end
      stalled = (bus.out_valid === 1'b1) && !bus.out_ready;
      held    = bus.out_data;
      if (done === 1'b1) begin
        seen_done = 1'b1;
        n_tests++;
        if (nxt != 512 || c != last_pop + 1) begin
          n_fail++; $display("FAIL rand_done got words=%0d gap=%0d exp words=512 gap=1", nxt, c - last_pop);
        end
      end
    end
    n_tests++;
    if (!seen_done) begin
      n_fail++; $display("FAIL rand_timeout got no done exp done within 3000 cycles");
    end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_start_ignored();
    do_preload();
    @(posedge clk); #1 start = 1'b1; mode = 1'b1; bus.out_ready = 1'b1;
    for (int c = 1; c <= 517; c++) begin
      @(posedge clk); #1 start = (c == 101); mode = 1'b0; bus.in_valid = (c >= 101);
      @(negedge clk);
      if (c >= 3 && c <= 514) begin
        n_tests++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== DATA_W'(c - 3)) begin
          n_fail++; $display("FAIL ign_data c=%0d got %b/%0d exp 1/%0d", c, bus.out_valid, bus.out_data, c - 3);
        end
      end
      n_tests++;
      if (done !== (c == 515) || bus.in_ready !== 1'b0 || bus.bank_we !== 4'b0000) begin
        n_fail++; $display("FAIL ign_ctrl c=%0d got done=%b rdy=%b we=%b exp done=%b rdy=0 we=0000",
                           c, done, bus.in_ready, bus.bank_we, (c == 515));
      end
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_load();
    wv_t exp;
    @(posedge clk); #1 start = 1'b1; mode = 1'b0; bus.in_valid = 1'b1; bus.in_data = '0;
    for (int c = 1; c <= 201; c++) begin
      @(posedge clk); #1 start = 1'b0; bus.in_data = DATA_W'(c - 1); rst = (c == 201);
    end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({busy, bus.in_ready, bus.bank_we} !== 6'b0) begin
      n_fail++; $display("FAIL midrst got busy=%b rdy=%b we=%b exp 0/0/0000", busy, bus.in_ready, bus.bank_we);
    end
    @(posedge clk); #1 start = 1'b1; bus.in_data = '0;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1 start = 1'b0; bus.in_data = DATA_W'(1000 + c - 1);
      @(negedge clk);
      exp = (c >= 2) ? exp_wr(c - 2, 1000 + c - 2) : '0;
      n_tests++;
      if (wr_bus !== exp) begin
        n_fail++; $display("FAIL restart_write c=%0d got %h exp %h", c, wr_bus, exp);
      end
    end
    @(posedge clk); #1 rst = 1'b1; bus.in_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mode = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
    test_reset();
    test_load_stream();
    test_load_toggle();
    test_unload_stream();
    test_unload_random();
    test_start_ignored();
    test_reset_mid_load();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got no completion exp finish before time 1000000");
    $fatal(1, "watchdog expired");
  end

endmodule
